// File: rtl/tune_pkg.sv
// Shared types and default sizing for the tune sequencer and its normaliser.
package tune_pkg;

    localparam int unsigned W_DEF        = 40;
    localparam int unsigned TOPBITS_DEF  = 12;
    localparam int unsigned DIV_BASE_DEF = 12;
    localparam int unsigned DIV_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_EDGE
    } state_t;

endpackage

// File: rtl/tune_normaliser.sv
// Right-shifts a captured omega word until its top TOPBITS bits are zero,
// counting the shifts; done is asserted once no further shift is needed.
module tune_normaliser
    import tune_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned TOPBITS = TOPBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     work,
    output logic [DIV_W-1:0] cnt,
    output logic             done
);

    logic need_shift;

    always_comb begin
        need_shift = (|work[W-1 -: TOPBITS]) && (cnt < DIV_W'(TOPBITS));
        done       = !need_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
        end else if (start) begin
            work <= din;
            cnt  <= '0;
        end else if (enable && need_shift) begin
            work <= work >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tune_sequencer.sv
// Normalises a new omega word and commits it with its divider select on a
// divided-clock edge. Optional WAIT_EDGE watchdog: define TUNE_TIMEOUT_EN.
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned TOPBITS  = TOPBITS_DEF,
    parameter int unsigned DIV_BASE = DIV_BASE_DEF
`ifdef TUNE_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 4095
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     omega_in,
    input  logic             omega_valid,
    input  logic             div_tick,
    output logic [W-1:0]     sd_kin,
    output logic [DIV_W-1:0] div_n,
    output logic             apply,
    output logic             sd_hold,
    output logic             busy
`ifdef TUNE_TIMEOUT_EN
    , output logic           timeout
`endif
);

    state_t             state, state_nx;
    logic               start, commit, tick_eff;
    logic [W-1:0]       load_word;
    logic [W-1:0]       pend_word;
    logic               pend_valid;
    logic [W-1:0]       work;
    logic [DIV_W-1:0]   cnt;
    logic               norm_done;

    tune_normaliser #(
        .W       (W),
        .TOPBITS (TOPBITS)
    ) u_norm (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .enable (state == SHIFT),
        .din    (load_word),
        .work   (work),
        .cnt    (cnt),
        .done   (norm_done)
    );

`ifdef TUNE_TIMEOUT_EN
    logic [11:0] wd_cnt;
    logic        wd_expire;

    assign wd_expire = (state == WAIT_EDGE) && (wd_cnt == 12'(TIMEOUT_CYC - 1));
    assign tick_eff  = div_tick || wd_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_EDGE && !commit) ? wd_cnt + 1'b1 : '0;
            if (wd_expire && !div_tick)
                timeout <= 1'b1;
        end
    end
`else
    assign tick_eff = div_tick;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start)     state_nx = SHIFT;
            SHIFT:     if (norm_done) state_nx = WAIT_EDGE;
            WAIT_EDGE: if (tick_eff)  state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // A full pending slot is served before a same-cycle omega_valid; the
    // equality check is applied to whichever word is actually loaded.
    always_comb begin
        busy      = (state != IDLE);
        sd_hold   = (state == WAIT_EDGE);
        commit    = sd_hold && tick_eff;
        load_word = pend_valid ? pend_word : omega_in;
        start     = (state == IDLE) && (pend_valid || omega_valid) && (load_word != sd_kin);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_kin     <= '0;
            div_n      <= DIV_W'(DIV_BASE);
            apply      <= 1'b0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
        end else begin
            apply <= commit;
            if (commit) begin
                sd_kin <= work;
                div_n  <= DIV_W'(DIV_BASE) - cnt;
            end
            if (omega_valid && (state != IDLE || pend_valid)) begin
                pend_word  <= omega_in;
                pend_valid <= 1'b1;
            end else if (state == IDLE) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
